simmem_bank_timing_model: RTL and testbench
===========================================

# simmem_bank_timing_model

Multi-bank DRAM timing model for the simulated memory controller. Accepts address requests tagged with an internal identifier and tracks a row buffer per bank. Charges each access a row-hit, row-miss or row-conflict latency, and releases a tagged completion when that latency has elapsed. It sits between the response banks, which supply the internal IDs, and the release logic. It generalises the single fixed-cost delay model to NumBanks independent banks, with a selectable open-page or closed-page policy.

## Interface
- NumBanks, 4: number of banks; must be a power of two, at least 1.
- AddrW, 16: request address width.
- RowBufLenW, 10: log2 of the row length in bytes.
- RowHitCost, 10: cycles for a column access; must be at least 1.
- PrechargeCost, 50: precharge cycles.
- ActivationCost, 45: activation cycles.
- IidW, 5: internal identifier width.
- DelayW, 8: counter and delay width.
- ClosedPage, 0: page policy. 0 selects open-page; 1 selects closed-page.

Elaboration assertions:
- PrechargeCost+ActivationCost+RowHitCost < 2**DelayW.
- RowBufLenW+log2(NumBanks) ≤ AddrW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  target bank can accept.
- req_addr_i  in  AddrW  request byte address.
- req_iid_i  in  IidW  internal identifier.
- rsp_valid_o  out  1  completion valid.
- rsp_ready_i  in  1  completion accepted.
- rsp_iid_o  out  IidW  identifier of the completed request.
- rsp_delay_o  out  DelayW  cycles charged to that request.
- rsp_kind_o  out  2  access kind: 0 hit, 1 miss (bank was closed), 2 conflict.

## Operation
Address fields:
- Bank index: req_addr_i[RowBufLenW +: log2(NumBanks)]. When NumBanks is 1, the bank index is always 0.
- Row id: req_addr_i[AddrW-1:RowBufLenW]. The bank bits are included.

Each bank holds a state, an open row id, a down-counter, a stored iid, a stored cost and a stored kind. Bank states:
- CLOSED: no row open; accepts requests.
- OPEN: a row is open; accepts requests. Never entered when ClosedPage=1.
- ACCESS: counter running.
- DONE: completion waiting for the output arbiter.
- PRECHG: closed-page recovery.

Readiness:
- req_ready_o = target bank is CLOSED or OPEN. It is combinational from req_addr_i and bank state only, and does not depend on req_valid_i.

Cost and kind, computed at acceptance:
- Bank CLOSED: cost is ActivationCost+RowHitCost, kind 1.
- Bank OPEN, same row: cost is RowHitCost, kind 0.
- Bank OPEN, different row: cost is PrechargeCost+ActivationCost+RowHitCost, kind 2.

Transitions:
- On accept: the bank moves to ACCESS. It loads counter=cost-1 and latches iid, cost, kind and the row id.
- ACCESS: the counter decrements each cycle. When the counter is 0, the bank moves to DONE on the next edge.
- DONE: the output arbiter selects among DONE banks round-robin. The pointer starts at bank 0 and, after each handshake, advances to one past the granted bank.
- The selected bank drives rsp_* from its stored fields. rsp_delay_o equals the stored cost.
- On rsp handshake with ClosedPage=0: the bank moves to OPEN, keeping its row.
- On rsp handshake with ClosedPage=1: the bank loads counter=PrechargeCost-1 and moves to PRECHG. When that counter reaches 0, it moves to CLOSED.
- A bank never accepts a new request in the same cycle as its own rsp handshake.

## Timing
- Accept at edge t. rsp_valid_o is asserted at the earliest from the cycle after edge t+cost. If rsp_ready_i is held high and there is no contention, the response handshake happens at edge t+cost+1.
- Once rsp_valid_o is asserted, rsp_iid_o, rsp_delay_o and rsp_kind_o stay stable until the handshake.
- The output arbiter does not reselect while rsp_valid_o is high and rsp_ready_i is low.
- Requests to different banks proceed concurrently, at up to one acceptance per cycle.
- Stall behaviour:
  - A bank held in DONE by backpressure stays unavailable.
  - Its latency excess is not added to rsp_delay_o.
- Reset (also mid-operation):
  - All banks go to CLOSED, and all counters, open rows and stored fields are cleared to 0.
  - Round-robin pointer returns to 0.
  - rsp_valid_o=0, rsp_iid_o=0, rsp_delay_o=0, rsp_kind_o=0.
  - req_ready_o=1.
  - In-flight requests are discarded.

## Test plan
- Reset, then request addr 0x0000 iid 3 -> rsp iid 3, kind 1, delay 55, valid 55 cycles after the accept. Repeat to addr 0x0004 -> kind 0, delay 10.
- Open-page conflict: accept addr 0x0000, then addr 0x1000 (same bank 0, different row) -> second response kind 2, delay 105.
- Four requests to banks 0..3 on consecutive cycles, with rsp_ready_i=0 until all are DONE -> responses in round-robin order 0,1,2,3; each iid stable under backpressure; req_ready_o=0 for each busy bank.
- ClosedPage=1: two hits to the same row -> both kind 1, delay 55. req_ready_o for that bank stays 0 for 50 cycles after the first rsp handshake.
- Assert rst_i while two banks are in ACCESS -> the next cycle has rsp_valid_o=0 and req_ready_o=1. A fresh request to the previously open row reports kind 1.

Source files
------------

// File: rtl/simmem_bank_timing_model.sv
// Multi-bank DRAM timing model. Each bank keeps a row buffer and charges
// every accepted request a row-hit, row-miss or row-conflict latency, then
// presents a tagged completion through a round-robin output arbiter.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   req_valid_i  request valid
//   req_ready_o  target bank (decoded from req_addr_i) can accept
//   req_addr_i   request byte address
//   req_iid_i    internal identifier of the request
//   rsp_valid_o  completion valid
//   rsp_ready_i  completion accepted
//   rsp_iid_o    identifier of the completed request
//   rsp_delay_o  cycles charged to that request
//   rsp_kind_o   0 hit, 1 miss (bank closed), 2 conflict
module simmem_bank_timing_model #(
  parameter int unsigned NumBanks       = 4,
  parameter int unsigned AddrW          = 16,
  parameter int unsigned RowBufLenW     = 10,
  parameter int unsigned RowHitCost     = 10,
  parameter int unsigned PrechargeCost  = 50,
  parameter int unsigned ActivationCost = 45,
  parameter int unsigned IidW           = 5,
  parameter int unsigned DelayW         = 8,
  parameter int unsigned ClosedPage     = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AddrW-1:0]  req_addr_i,
  input  logic [IidW-1:0]   req_iid_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IidW-1:0]   rsp_iid_o,
  output logic [DelayW-1:0] rsp_delay_o,
  output logic [1:0]        rsp_kind_o
);

  localparam int unsigned BankBits = (NumBanks > 1) ? $clog2(NumBanks) : 0;
  localparam int unsigned BankW    = (NumBanks > 1) ? BankBits : 1;
  localparam int unsigned RowW     = AddrW - RowBufLenW;

  localparam logic [DelayW-1:0] HitCost      = DelayW'(RowHitCost);
  localparam logic [DelayW-1:0] MissCost     = DelayW'(ActivationCost + RowHitCost);
  localparam logic [DelayW-1:0] ConflictCost = DelayW'(PrechargeCost + ActivationCost + RowHitCost);
  localparam logic [DelayW-1:0] PrechgLoad   = DelayW'(PrechargeCost - 1);

  if (PrechargeCost + ActivationCost + RowHitCost >= (1 << DelayW)) begin : g_chk_cost
    $error("PrechargeCost+ActivationCost+RowHitCost must be below 2**DelayW");
  end
  if (RowBufLenW + BankBits > AddrW) begin : g_chk_addr
    $error("RowBufLenW+log2(NumBanks) must not exceed AddrW");
  end
  if (NumBanks == 0 || (NumBanks & (NumBanks - 1)) != 0) begin : g_chk_banks
    $error("NumBanks must be a power of two, at least 1");
  end
  if (RowHitCost == 0) begin : g_chk_hit
    $error("RowHitCost must be at least 1");
  end

  typedef enum logic [2:0] {
    BANK_CLOSED,
    BANK_OPEN,
    BANK_ACCESS,
    BANK_DONE,
    BANK_PRECHG
  } bank_state_e;

  bank_state_e       state_q [NumBanks];
  logic [RowW-1:0]   row_q   [NumBanks];
  logic [DelayW-1:0] cnt_q   [NumBanks];
  logic [IidW-1:0]   iid_q   [NumBanks];
  logic [DelayW-1:0] cost_q  [NumBanks];
  logic [1:0]        kind_q  [NumBanks];

  logic [BankW-1:0]  ptr_q;
  logic              lock_q;
  logic [BankW-1:0]  lock_idx_q;

  logic [BankW-1:0]  req_bank;
  logic [RowW-1:0]   req_row;
  logic              accept;
  logic [DelayW-1:0] acc_cost;
  logic [1:0]        acc_kind;

  logic              pick_found;
  logic [BankW-1:0]  pick_idx;
  logic [BankW-1:0]  sel_idx;
  logic              rsp_hs;

  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr_i[RowBufLenW-1:0];

  if (NumBanks > 1) begin : g_bank_idx
    assign req_bank = req_addr_i[RowBufLenW +: BankW];
  end else begin : g_single_bank
    assign req_bank = '0;
  end

  assign req_row     = req_addr_i[AddrW-1:RowBufLenW];
  assign req_ready_o = (state_q[req_bank] == BANK_CLOSED) || (state_q[req_bank] == BANK_OPEN);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    acc_cost = MissCost;
    acc_kind = 2'd1;
    if (state_q[req_bank] == BANK_OPEN) begin
      if (row_q[req_bank] == req_row) begin
        acc_cost = HitCost;
        acc_kind = 2'd0;
      end else begin
        acc_cost = ConflictCost;
        acc_kind = 2'd2;
      end
    end
  end

  // First DONE bank at or after the round-robin pointer; the power-of-two
  // bank count makes the index wrap naturally.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NumBanks; k++) begin
      if (!pick_found && state_q[ptr_q + BankW'(k)] == BANK_DONE) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + BankW'(k);
      end
    end
  end

  // A stalled completion keeps its grant so the response fields stay put
  // even if a higher-priority bank finishes meanwhile.
  assign sel_idx     = lock_q ? lock_idx_q : pick_idx;
  assign rsp_valid_o = lock_q || pick_found;
  assign rsp_hs      = rsp_valid_o && rsp_ready_i;
  assign rsp_iid_o   = rsp_valid_o ? iid_q[sel_idx]  : '0;
  assign rsp_delay_o = rsp_valid_o ? cost_q[sel_idx] : '0;
  assign rsp_kind_o  = rsp_valid_o ? kind_q[sel_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NumBanks; k++) begin
        state_q[k] <= BANK_CLOSED;
        row_q[k]   <= '0;
        cnt_q[k]   <= '0;
        iid_q[k]   <= '0;
        cost_q[k]  <= '0;
        kind_q[k]  <= '0;
      end
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NumBanks; k++) begin
        case (state_q[k])
          BANK_CLOSED, BANK_OPEN: begin
            if (accept && req_bank == BankW'(k)) begin
              state_q[k] <= BANK_ACCESS;
              cnt_q[k]   <= acc_cost - DelayW'(1);
              iid_q[k]   <= req_iid_i;
              cost_q[k]  <= acc_cost;
              kind_q[k]  <= acc_kind;
              row_q[k]   <= req_row;
            end
          end
          BANK_ACCESS: begin
            if (cnt_q[k] == '0) begin
              state_q[k] <= BANK_DONE;
            end else begin
              cnt_q[k] <= cnt_q[k] - DelayW'(1);
            end
          end
          BANK_DONE: begin
            if (rsp_hs && sel_idx == BankW'(k)) begin
              if (ClosedPage == 0) begin
                state_q[k] <= BANK_OPEN;
              end else if (PrechargeCost == 0) begin
                state_q[k] <= BANK_CLOSED;
              end else begin
                state_q[k] <= BANK_PRECHG;
                cnt_q[k]   <= PrechgLoad;
              end
            end
          end
          BANK_PRECHG: begin
            if (cnt_q[k] == '0) begin
              state_q[k] <= BANK_CLOSED;
            end else begin
              cnt_q[k] <= cnt_q[k] - DelayW'(1);
            end
          end
          default: state_q[k] <= BANK_CLOSED;
        endcase
      end
      if (rsp_hs) begin
        ptr_q <= sel_idx + BankW'(1);
      end
      lock_q     <= rsp_valid_o && !rsp_ready_i;
      lock_idx_q <= sel_idx;
    end
  end

endmodule

// File: tb/tb_simmem_bank_timing_model.sv
module tb_simmem_bank_timing_model;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // open-page instance
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [4:0]  req_iid = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_iid;
  logic [7:0]  rsp_delay;
  logic [1:0]  rsp_kind;

  // closed-page instance
  logic        c_req_valid = 1'b0;
  logic        c_req_ready;
  logic [15:0] c_req_addr = '0;
  logic [4:0]  c_req_iid = '0;
  logic        c_rsp_valid;
  logic        c_rsp_ready = 1'b0;
  logic [4:0]  c_rsp_iid;
  logic [7:0]  c_rsp_delay;
  logic [1:0]  c_rsp_kind;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simmem_bank_timing_model #(.NumBanks(4), .ClosedPage(0)) dut_open (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_iid_i(req_iid),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_iid_o(rsp_iid), .rsp_delay_o(rsp_delay), .rsp_kind_o(rsp_kind)
  );

  simmem_bank_timing_model #(.NumBanks(4), .ClosedPage(1)) dut_closed (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(c_req_valid), .req_ready_o(c_req_ready),
    .req_addr_i(c_req_addr), .req_iid_i(c_req_iid),
    .rsp_valid_o(c_rsp_valid), .rsp_ready_i(c_rsp_ready),
    .rsp_iid_o(c_rsp_iid), .rsp_delay_o(c_rsp_delay), .rsp_kind_o(c_rsp_kind)
  );

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_o(input logic [15:0] addr, input logic [4:0] iid);
    req_addr  = addr;
    req_iid   = iid;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_c(input logic [15:0] addr, input logic [4:0] iid);
    c_req_addr  = addr;
    c_req_iid   = iid;
    c_req_valid = 1'b1;
    @(posedge clk); #1;
    c_req_valid = 1'b0;
  endtask

  // Cycles (edges) from the current point until rsp_valid is seen; 999 on timeout.
  task automatic wait_rsp_o(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!rsp_valid) cycles = 999;
  endtask

  task automatic wait_rsp_c(output int cycles);
    cycles = 0;
    while (!c_rsp_valid && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!c_rsp_valid) cycles = 999;
  endtask

  task automatic test_reset();
    do_reset();
    req_addr = 16'h0000;
    c_req_addr = 16'h0000;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_iid !== 5'd0 || rsp_delay !== 8'd0 || rsp_kind !== 2'd0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b iid=%0d delay=%0d kind=%0d, want all 0",
               rsp_valid, rsp_iid, rsp_delay, rsp_kind);
    end
    checks++;
    if (req_ready !== 1'b1 || c_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got open=%b closed=%b, want 1 1", req_ready, c_req_ready);
    end
  endtask

  task automatic test_miss_then_hit();
    int cyc;
    do_reset();
    rsp_ready = 1'b1;
    send_o(16'h0000, 5'd3);
    wait_rsp_o(cyc);
    checks++;
    if (cyc !== 55) begin
      errors++;
      $display("FAIL miss_latency: got %0d cycles, want 55", cyc);
    end
    checks++;
    if (rsp_iid !== 5'd3 || rsp_kind !== 2'd1 || rsp_delay !== 8'd55) begin
      errors++;
      $display("FAIL miss_fields: got iid=%0d kind=%0d delay=%0d, want 3 1 55", rsp_iid, rsp_kind, rsp_delay);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL miss_release: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    send_o(16'h0004, 5'd4);
    wait_rsp_o(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL hit_latency: got %0d cycles, want 10", cyc);
    end
    checks++;
    if (rsp_iid !== 5'd4 || rsp_kind !== 2'd0 || rsp_delay !== 8'd10) begin
      errors++;
      $display("FAIL hit_fields: got iid=%0d kind=%0d delay=%0d, want 4 0 10", rsp_iid, rsp_kind, rsp_delay);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    int cyc;
    do_reset();
    rsp_ready = 1'b1;
    send_o(16'h0000, 5'd1);
    wait_rsp_o(cyc);
    @(posedge clk); #1;
    send_o(16'h1000, 5'd2);
    wait_rsp_o(cyc);
    checks++;
    if (cyc !== 105) begin
      errors++;
      $display("FAIL conflict_latency: got %0d cycles, want 105", cyc);
    end
    checks++;
    if (rsp_iid !== 5'd2 || rsp_kind !== 2'd2 || rsp_delay !== 8'd105) begin
      errors++;
      $display("FAIL conflict_fields: got iid=%0d kind=%0d delay=%0d, want 2 2 105", rsp_iid, rsp_kind, rsp_delay);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int unstable;
    logic [15:0] addrs [4];
    addrs[0] = 16'h0000;
    addrs[1] = 16'h0400;
    addrs[2] = 16'h0800;
    addrs[3] = 16'h0C00;
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = addrs[i];
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_before bank%0d: got %b, want 1", i, req_ready);
      end
      send_o(addrs[i], 5'(10 + i));
    end
    for (int i = 0; i < 4; i++) begin
      req_addr = addrs[i];
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy bank%0d: got ready=%b, want 0", i, req_ready);
      end
    end
    wait_rsp_o(cyc);
    checks++;
    if (rsp_iid !== 5'd10) begin
      errors++;
      $display("FAIL b2b_first_iid: got %0d, want 10", rsp_iid);
    end
    // Hold backpressure past the point where every bank has finished.
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_iid !== 5'd10 || rsp_delay !== 8'd55 || rsp_kind !== 2'd1) unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL b2b_stable: got %0d unstable cycles, want 0", unstable);
    end
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_iid !== 5'(10 + i) || rsp_delay !== 8'd55 || rsp_kind !== 2'd1) begin
        errors++;
        $display("FAIL b2b_order slot%0d: got valid=%b iid=%0d delay=%0d kind=%0d, want 1 %0d 55 1",
                 i, rsp_valid, rsp_iid, rsp_delay, rsp_kind, 10 + i);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: got valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_closed_page();
    int cyc;
    int busy;
    do_reset();
    c_rsp_ready = 1'b1;
    send_c(16'h0000, 5'd5);
    wait_rsp_c(cyc);
    checks++;
    if (cyc !== 55 || c_rsp_iid !== 5'd5 || c_rsp_kind !== 2'd1 || c_rsp_delay !== 8'd55) begin
      errors++;
      $display("FAIL closed_first: got cyc=%0d iid=%0d kind=%0d delay=%0d, want 55 5 1 55",
               cyc, c_rsp_iid, c_rsp_kind, c_rsp_delay);
    end
    @(posedge clk); #1;
    busy = 0;
    while (c_req_ready === 1'b0 && busy < 200) begin
      busy++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 50) begin
      errors++;
      $display("FAIL closed_precharge: got %0d not-ready cycles, want 50", busy);
    end
    send_c(16'h0004, 5'd6);
    wait_rsp_c(cyc);
    checks++;
    if (cyc !== 55 || c_rsp_iid !== 5'd6 || c_rsp_kind !== 2'd1 || c_rsp_delay !== 8'd55) begin
      errors++;
      $display("FAIL closed_second: got cyc=%0d iid=%0d kind=%0d delay=%0d, want 55 6 1 55",
               cyc, c_rsp_iid, c_rsp_kind, c_rsp_delay);
    end
    @(posedge clk); #1;
    c_rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int cyc;
    do_reset();
    rsp_ready = 1'b1;
    send_o(16'h0000, 5'd1);
    wait_rsp_o(cyc);
    @(posedge clk); #1;
    send_o(16'h0004, 5'd6);
    send_o(16'h0400, 5'd7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_reset();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_iid !== 5'd0) begin
      errors++;
      $display("FAIL midrst_rsp: got valid=%b iid=%0d, want 0 0", rsp_valid, rsp_iid);
    end
    req_addr = 16'h0000;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready0: got %b, want 1", req_ready);
    end
    req_addr = 16'h0400;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready1: got %b, want 1", req_ready);
    end
    send_o(16'h0000, 5'd8);
    wait_rsp_o(cyc);
    checks++;
    if (cyc !== 55 || rsp_iid !== 5'd8 || rsp_kind !== 2'd1 || rsp_delay !== 8'd55) begin
      errors++;
      $display("FAIL midrst_fresh: got cyc=%0d iid=%0d kind=%0d delay=%0d, want 55 8 1 55",
               cyc, rsp_iid, rsp_kind, rsp_delay);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_miss_then_hit();
    test_conflict();
    test_back_to_back();
    test_closed_page();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
